axi_burst_sched: RTL and testbench

Parametrised multi-channel AXI burst scheduler, single clock domain. It sits between CH_NUM per-channel FIFOs and one AXI read or write master. For each channel it tracks a circular or one-shot address region, then issues burst commands (address, length, channel id) to the master over a valid/ready handshake. Channels share the master through round-robin arbitration. Every burst is clipped to the region end and to the AXI 4 KB boundary; MODE selects write scheduling (FIFO fill level) or read scheduling (FIFO free space).

---
 rtl/axi_burst_sched.sv | 185 ++++++++++++++++++
 tb/tb_axi_burst_sched.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_burst_sched.sv
// ============================================================================
// axi_burst_sched : round-robin AXI burst command scheduler for CH_NUM FIFOs
// Rev 1.0
// ============================================================================
`default_nettype none

module axi_burst_sched #(
  parameter int CH_NUM     = 2,
  parameter int ADDR_W     = 30,
  parameter int CNT_W      = 10,
  parameter int FIFO_DEPTH = 512,
  parameter int BPB_LOG2   = 3,
  parameter int MODE       = 0
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic [CH_NUM*ADDR_W-1:0]                   ch_beg_addr,
  input  logic [CH_NUM*ADDR_W-1:0]                   ch_end_addr,
  input  logic [CH_NUM*8-1:0]                        ch_burst_len,
  input  logic [CH_NUM-1:0]                          ch_en,
  input  logic [CH_NUM-1:0]                          ch_oneshot,
  input  logic [CH_NUM-1:0]                          ch_clr,
  input  logic [CH_NUM*CNT_W-1:0]                    ch_level,
  output logic                                       cmd_valid,
  input  logic                                       cmd_ready,
  output logic [ADDR_W-1:0]                          cmd_addr,
  output logic [7:0]                                 cmd_len,
  output logic [((CH_NUM > 1) ? $clog2(CH_NUM) : 1)-1:0] cmd_ch,
  input  logic                                       mst_done,
  output logic [CH_NUM-1:0]                          ch_done,
  output logic                                       busy
);

  localparam int c_ch_w = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
  localparam logic [ADDR_W-1:0] c_beat_bytes = ADDR_W'(1 << BPB_LOG2);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CALC  = 2'd1,
    S_ISSUE = 2'd2,
    S_WAIT  = 2'd3
  } state_t;

  state_t r_state, w_state_nxt;

  logic [ADDR_W-1:0] w_beg   [CH_NUM];
  logic [ADDR_W-1:0] w_end   [CH_NUM];
  logic [8:0]        w_std   [CH_NUM];
  logic [CNT_W-1:0]  w_level [CH_NUM];
  logic [CH_NUM-1:0] w_elig;

  logic [ADDR_W-1:0] r_addr [CH_NUM];
  logic [CH_NUM-1:0] r_done;

  logic              r_cmd_valid;
  logic [ADDR_W-1:0] r_cmd_addr;
  logic [7:0]        r_cmd_len;
  logic [c_ch_w-1:0] r_cmd_ch;
  logic [c_ch_w-1:0] r_grant;
  logic [c_ch_w-1:0] r_last_grant;

  logic              w_found;
  logic [c_ch_w-1:0] w_pick;
  logic [ADDR_W-1:0] w_cur_addr, w_cur_end;
  logic [8:0]        w_cur_std;
  logic [ADDR_W-1:0] w_to_end, w_beats, w_next;
  logic [12:0]       w_to_4k;
  logic              w_accept, w_wrap;

  // Per-channel field unpacking and eligibility
  generate
    for (genvar gi = 0; gi < CH_NUM; gi++) begin : g_ch
      assign w_beg[gi]   = ch_beg_addr[gi*ADDR_W +: ADDR_W];
      assign w_end[gi]   = ch_end_addr[gi*ADDR_W +: ADDR_W];
      assign w_level[gi] = ch_level[gi*CNT_W +: CNT_W];
      assign w_std[gi]   = {1'b0, ch_burst_len[gi*8 +: 8]} + 9'd1;
      if (MODE == 0) begin : g_wr
        assign w_elig[gi] = ch_en[gi] && !r_done[gi] &&
                            (32'(w_level[gi]) >= 32'(w_std[gi]));
      end else begin : g_rd
        // level + burst <= depth avoids underflow when level exceeds depth
        assign w_elig[gi] = ch_en[gi] && !r_done[gi] &&
                            ((32'(w_level[gi]) + 32'(w_std[gi])) <= 32'(FIFO_DEPTH));
      end
    end
  endgenerate

  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    for (int k = 1; k <= CH_NUM; k++) begin
      if (!w_found && w_elig[c_ch_w'((int'(r_last_grant) + k) % CH_NUM)]) begin
        w_found = 1'b1;
        w_pick  = c_ch_w'((int'(r_last_grant) + k) % CH_NUM);
      end
    end
  end

  assign w_cur_addr = r_addr[r_grant];
  assign w_cur_end  = w_end[r_grant];
  assign w_cur_std  = w_std[r_grant];

  assign w_to_end = (w_cur_end - w_cur_addr + ADDR_W'(1)) >> BPB_LOG2;
  assign w_to_4k  = (13'd4096 - {1'b0, w_cur_addr[11:0]}) >> BPB_LOG2;

  always_comb begin
    w_beats = ADDR_W'(w_cur_std);
    if (w_to_end < w_beats) w_beats = w_to_end;
    if (ADDR_W'(w_to_4k) < w_beats) w_beats = ADDR_W'(w_to_4k);
  end

  assign w_accept = (r_state == S_ISSUE) && r_cmd_valid && cmd_ready;
  assign w_next   = r_cmd_addr + (ADDR_W'({1'b0, r_cmd_len} + 9'd1) << BPB_LOG2);
  assign w_wrap   = (w_next > w_cur_end) ||
                    ((w_cur_end - w_next + ADDR_W'(1)) < c_beat_bytes);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_found)  w_state_nxt = S_CALC;
      S_CALC:                w_state_nxt = S_ISSUE;
      S_ISSUE: if (w_accept) w_state_nxt = S_WAIT;
      S_WAIT:  if (mst_done) w_state_nxt = S_IDLE;
      default:               w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cmd_valid  <= 1'b0;
      r_cmd_addr   <= '0;
      r_cmd_len    <= '0;
      r_cmd_ch     <= '0;
      r_grant      <= '0;
      r_last_grant <= c_ch_w'(CH_NUM - 1);
    end else begin
      case (r_state)
        S_IDLE: if (w_found) begin
          r_grant      <= w_pick;
          r_last_grant <= w_pick;
        end
        S_CALC: begin
          r_cmd_addr  <= w_cur_addr;
          r_cmd_len   <= 8'(w_beats - ADDR_W'(1));
          r_cmd_ch    <= r_grant;
          r_cmd_valid <= 1'b1;
        end
        S_ISSUE: if (w_accept) r_cmd_valid <= 1'b0;
        default: ;
      endcase
    end
  end

  // Clear wins over the post-acceptance address advance
  always_ff @(posedge clk) begin
    for (int i = 0; i < CH_NUM; i++) begin
      if (rst || ch_clr[i]) begin
        r_addr[i] <= w_beg[i];
        r_done[i] <= 1'b0;
      end else if (w_accept && (r_grant == c_ch_w'(i))) begin
        if (w_wrap) begin
          if (ch_oneshot[i]) r_done[i] <= 1'b1;
          else               r_addr[i] <= w_beg[i];
        end else begin
          r_addr[i] <= w_next;
        end
      end
    end
  end

  assign cmd_valid = r_cmd_valid;
  assign cmd_addr  = r_cmd_addr;
  assign cmd_len   = r_cmd_len;
  assign cmd_ch    = r_cmd_ch;
  assign ch_done   = r_done;
  assign busy      = (r_state != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_axi_burst_sched.sv
// ============================================================================
// tb_axi_burst_sched : directed self-checking bench for axi_burst_sched
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_axi_burst_sched;

  localparam int AW = 30;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // write-mode instance, two channels
  logic            rst0 = 1'b1;
  logic [2*AW-1:0] d0_beg = '0, d0_end = '0;
  logic [15:0]     d0_len = '0;
  logic [1:0]      d0_en = '0, d0_os = '0, d0_clr = '0;
  logic [19:0]     d0_lvl = {10'd20, 10'd20};
  logic            d0_cmd_valid, d0_cmd_ready = 1'b1, d0_mst_done = 1'b0;
  logic [AW-1:0]   d0_cmd_addr;
  logic [7:0]      d0_cmd_len;
  logic [0:0]      d0_cmd_ch;
  logic [1:0]      d0_ch_done;
  logic            d0_busy;

  // read-mode instance, one channel, master never ready
  logic            rst1 = 1'b1;
  logic [AW-1:0]   d1_beg = '0, d1_end = 30'hFFFF;
  logic [7:0]      d1_len = 8'd15;
  logic [0:0]      d1_en = 1'b1, d1_os = 1'b0, d1_clr = 1'b0;
  logic [9:0]      d1_lvl = 10'd500;
  logic            d1_cmd_valid, d1_cmd_ready = 1'b0, d1_mst_done = 1'b0;
  logic [AW-1:0]   d1_cmd_addr;
  logic [7:0]      d1_cmd_len;
  logic [0:0]      d1_cmd_ch;
  logic [0:0]      d1_ch_done;
  logic            d1_busy;

  axi_burst_sched #(.CH_NUM(2), .ADDR_W(AW), .CNT_W(10), .FIFO_DEPTH(512),
                    .BPB_LOG2(3), .MODE(0)) u_wr (
    .clk(clk), .rst(rst0),
    .ch_beg_addr(d0_beg), .ch_end_addr(d0_end), .ch_burst_len(d0_len),
    .ch_en(d0_en), .ch_oneshot(d0_os), .ch_clr(d0_clr), .ch_level(d0_lvl),
    .cmd_valid(d0_cmd_valid), .cmd_ready(d0_cmd_ready), .cmd_addr(d0_cmd_addr),
    .cmd_len(d0_cmd_len), .cmd_ch(d0_cmd_ch), .mst_done(d0_mst_done),
    .ch_done(d0_ch_done), .busy(d0_busy)
  );

  axi_burst_sched #(.CH_NUM(1), .ADDR_W(AW), .CNT_W(10), .FIFO_DEPTH(512),
                    .BPB_LOG2(3), .MODE(1)) u_rd (
    .clk(clk), .rst(rst1),
    .ch_beg_addr(d1_beg), .ch_end_addr(d1_end), .ch_burst_len(d1_len),
    .ch_en(d1_en), .ch_oneshot(d1_os), .ch_clr(d1_clr), .ch_level(d1_lvl),
    .cmd_valid(d1_cmd_valid), .cmd_ready(d1_cmd_ready), .cmd_addr(d1_cmd_addr),
    .cmd_len(d1_cmd_len), .cmd_ch(d1_cmd_ch), .mst_done(d1_mst_done),
    .ch_done(d1_ch_done), .busy(d1_busy)
  );

  task automatic cfg(input int ch, input logic [AW-1:0] b, input logic [AW-1:0] e,
                     input logic [7:0] l, input logic enb, input logic osb);
    d0_beg[ch*AW +: AW] = b;
    d0_end[ch*AW +: AW] = e;
    d0_len[ch*8 +: 8]   = l;
    d0_en[ch]           = enb;
    d0_os[ch]           = osb;
  endtask

  task automatic reset0();
    @(posedge clk); #1 rst0 = 1'b1;
    @(posedge clk); #1 rst0 = 1'b0;
  endtask

  // Waits (bounded) for a command on u_wr, accepts it, then pulses mst_done.
  // On timeout all outputs stay X so the caller's comparisons fail.
  task automatic get_cmd(output logic [AW-1:0] a, output logic [7:0] l,
                         output logic c, output logic d);
    bit got = 0;
    a = 'x; l = 'x; c = 1'bx; d = 1'bx;
    for (int n = 0; n < 60 && !got; n++) begin
      @(negedge clk);
      if (d0_cmd_valid) begin
        got = 1; a = d0_cmd_addr; l = d0_cmd_len; c = d0_cmd_ch;
      end
    end
    if (got) begin
      @(posedge clk);
      @(negedge clk); d = d0_ch_done[0];
      @(posedge clk); #1 d0_mst_done = 1'b1;
      @(posedge clk); #1 d0_mst_done = 1'b0;
    end
  endtask

  task automatic test_reset();
    cfg(0, '0, '0, 8'd15, 1'b0, 1'b0);
    cfg(1, '0, '0, 8'd15, 1'b0, 1'b0);
    reset0();
    @(negedge clk);
    checks += 6;
    if (d0_cmd_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", d0_cmd_valid); end
    if (d0_cmd_addr !== '0) begin errors++; $display("FAIL reset_addr got %h exp 0", d0_cmd_addr); end
    if (d0_cmd_len !== 8'd0) begin errors++; $display("FAIL reset_len got %h exp 0", d0_cmd_len); end
    if (d0_cmd_ch !== 1'b0) begin errors++; $display("FAIL reset_ch got %b exp 0", d0_cmd_ch); end
    if (d0_ch_done !== 2'b00) begin errors++; $display("FAIL reset_done got %b exp 00", d0_ch_done); end
    if (d0_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", d0_busy); end
  endtask

  task automatic test_circular();
    logic [AW-1:0] a; logic [7:0] l; logic c, d;
    cfg(0, 30'h0, 30'h3FF, 8'd15, 1'b1, 1'b0);
    cfg(1, 30'h0, 30'h3FF, 8'd15, 1'b0, 1'b0);
    reset0();
    for (int i = 0; i < 9; i++) begin
      get_cmd(a, l, c, d);
      checks += 2;
      if (a !== AW'((i % 8) * 'h80)) begin errors++; $display("FAIL circ_addr[%0d] got %h exp %h", i, a, (i % 8) * 'h80); end
      if (l !== 8'd15) begin errors++; $display("FAIL circ_len[%0d] got %0d exp 15", i, l); end
    end
  endtask

  task automatic test_end_clip();
    logic [AW-1:0] a; logic [7:0] l; logic c, d;
    logic [AW-1:0] ea [4] = '{30'h000, 30'h080, 30'h100, 30'h000};
    logic [7:0]    el [4] = '{8'd15, 8'd15, 8'd7, 8'd15};
    cfg(0, 30'h0, 30'h13F, 8'd15, 1'b1, 1'b0);
    reset0();
    for (int i = 0; i < 4; i++) begin
      get_cmd(a, l, c, d);
      checks += 2;
      if (a !== ea[i]) begin errors++; $display("FAIL clip_addr[%0d] got %h exp %h", i, a, ea[i]); end
      if (l !== el[i]) begin errors++; $display("FAIL clip_len[%0d] got %0d exp %0d", i, l, el[i]); end
    end
  endtask

  task automatic test_4k_split();
    logic [AW-1:0] a; logic [7:0] l; logic c, d;
    logic [AW-1:0] ea [2] = '{30'hFC0, 30'h1000};
    logic [7:0]    el [2] = '{8'd7, 8'd15};
    cfg(0, 30'hFC0, 30'h1FFF, 8'd15, 1'b1, 1'b0);
    reset0();
    for (int i = 0; i < 2; i++) begin
      get_cmd(a, l, c, d);
      checks += 2;
      if (a !== ea[i]) begin errors++; $display("FAIL split4k_addr[%0d] got %h exp %h", i, a, ea[i]); end
      if (l !== el[i]) begin errors++; $display("FAIL split4k_len[%0d] got %0d exp %0d", i, l, el[i]); end
    end
  endtask

  task automatic test_round_robin();
    logic [AW-1:0] a; logic [7:0] l; logic c, d;
    logic          ec [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [AW-1:0] ea [4] = '{30'h0, 30'h2000, 30'h80, 30'h2080};
    cfg(0, 30'h0, 30'h3FF, 8'd15, 1'b1, 1'b0);
    cfg(1, 30'h2000, 30'h23FF, 8'd15, 1'b1, 1'b0);
    reset0();
    for (int i = 0; i < 4; i++) begin
      get_cmd(a, l, c, d);
      checks += 2;
      if (c !== ec[i]) begin errors++; $display("FAIL rr_ch[%0d] got %b exp %b", i, c, ec[i]); end
      if (a !== ea[i]) begin errors++; $display("FAIL rr_addr[%0d] got %h exp %h", i, a, ea[i]); end
    end
    cfg(0, 30'h0, 30'h3FF, 8'd15, 1'b0, 1'b0);
    reset0();
    for (int i = 0; i < 3; i++) begin
      get_cmd(a, l, c, d);
      checks += 2;
      if (c !== 1'b1) begin errors++; $display("FAIL rr_en0_ch[%0d] got %b exp 1", i, c); end
      if (a !== AW'('h2000 + i * 'h80)) begin errors++; $display("FAIL rr_en0_addr[%0d] got %h exp %h", i, a, 'h2000 + i * 'h80); end
    end
    cfg(1, 30'h2000, 30'h23FF, 8'd15, 1'b0, 1'b0);
  endtask

  task automatic test_oneshot();
    logic [AW-1:0] a; logic [7:0] l; logic c, d;
    int cnt = 0;
    cfg(0, 30'h0, 30'hFF, 8'd15, 1'b1, 1'b1);
    reset0();
    get_cmd(a, l, c, d);
    checks += 2;
    if (a !== 30'h0) begin errors++; $display("FAIL os_addr0 got %h exp 0", a); end
    if (d !== 1'b0) begin errors++; $display("FAIL os_done0 got %b exp 0", d); end
    get_cmd(a, l, c, d);
    checks += 3;
    if (a !== 30'h80) begin errors++; $display("FAIL os_addr1 got %h exp 80", a); end
    if (l !== 8'd15) begin errors++; $display("FAIL os_len1 got %0d exp 15", l); end
    if (d !== 1'b1) begin errors++; $display("FAIL os_done1 got %b exp 1", d); end
    repeat (20) begin
      @(negedge clk);
      if (d0_cmd_valid) cnt++;
    end
    checks += 2;
    if (cnt !== 0) begin errors++; $display("FAIL os_no_more got %0d valid cycles exp 0", cnt); end
    if (d0_busy !== 1'b0) begin errors++; $display("FAIL os_idle_busy got %b exp 0", d0_busy); end
    @(posedge clk); #1 d0_clr[0] = 1'b1;
    @(posedge clk); #1 d0_clr[0] = 1'b0;
    @(negedge clk);
    checks += 1;
    if (d0_ch_done[0] !== 1'b0) begin errors++; $display("FAIL os_clr_done got %b exp 0", d0_ch_done[0]); end
    get_cmd(a, l, c, d);
    checks += 1;
    if (a !== 30'h0) begin errors++; $display("FAIL os_clr_addr got %h exp 0", a); end
  endtask

  task automatic test_read_mode();
    int cnt = 0;
    d1_en = 1'b1; d1_lvl = 10'd500;
    @(posedge clk); #1 rst1 = 1'b1;
    @(posedge clk); #1 rst1 = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (d1_cmd_valid) cnt++;
    end
    checks += 1;
    if (cnt !== 0) begin errors++; $display("FAIL rd_lvl500 got %0d valid cycles exp 0", cnt); end
    @(posedge clk); #1 d1_lvl = 10'd496;
    @(posedge clk);
    @(negedge clk);
    checks += 2;
    if (d1_cmd_valid !== 1'b0) begin errors++; $display("FAIL rd_lat1_valid got %b exp 0", d1_cmd_valid); end
    if (d1_busy !== 1'b1) begin errors++; $display("FAIL rd_lat1_busy got %b exp 1", d1_busy); end
    @(posedge clk);
    @(negedge clk);
    checks += 3;
    if (d1_cmd_valid !== 1'b1) begin errors++; $display("FAIL rd_lat2_valid got %b exp 1", d1_cmd_valid); end
    if (d1_cmd_addr !== 30'h0) begin errors++; $display("FAIL rd_addr got %h exp 0", d1_cmd_addr); end
    if (d1_cmd_len !== 8'd15) begin errors++; $display("FAIL rd_len got %0d exp 15", d1_cmd_len); end
  endtask

  task automatic test_reset_in_issue();
    int cnt = 0;
    @(posedge clk); #1 rst1 = 1'b1;
    @(negedge clk);
    checks += 1;
    if (d1_cmd_valid !== 1'b1) begin errors++; $display("FAIL issue_hold got %b exp 1", d1_cmd_valid); end
    @(posedge clk); #1 rst1 = 1'b0; d1_en = 1'b0;
    @(negedge clk);
    checks += 2;
    if (d1_cmd_valid !== 1'b0) begin errors++; $display("FAIL rst_issue_valid got %b exp 0", d1_cmd_valid); end
    if (d1_busy !== 1'b0) begin errors++; $display("FAIL rst_issue_busy got %b exp 0", d1_busy); end
    repeat (10) begin
      @(negedge clk);
      if (d1_cmd_valid || d1_busy) cnt++;
    end
    checks += 1;
    if (cnt !== 0) begin errors++; $display("FAIL rd_en0_block got %0d active cycles exp 0", cnt); end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    test_reset();
    test_circular();
    test_end_clip();
    test_4k_split();
    test_round_robin();
    test_oneshot();
    test_read_mode();
    test_reset_in_issue();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
